// File: rtl/dcache_ctrl.sv
// Data-cache controller: two-way set-associative, 16 sets, one 64-bit word per line.
// Define DCACHE_WB_EN for write-back/write-allocate; the default build is write-through.
module dcache_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  proc2dcache_command,
  input  logic [15:0] proc2dcache_addr,
  input  logic [63:0] proc2dcache_data,
  output logic [63:0] dcache2proc_data,
  output logic        dcache2proc_valid,
  output logic        dcache2proc_stall,
  output logic [3:0]  cache_index,
  output logic [8:0]  cache_tag,
  output logic [63:0] cache_wr_data,
  output logic        cache_wr_en,
  output logic        cache_write_back,
  output logic        cache_write_back_way,
  input  logic        cache_hit_way0,
  input  logic        cache_hit_way1,
  input  logic        cache_lru,
  input  logic [63:0] cache_rd_data,
  input  logic [8:0]  cache_tag_out,
  output logic [1:0]  proc2mem_command,
  output logic [15:0] proc2mem_addr,
  output logic [63:0] proc2mem_data,
  input  logic [3:0]  mem2proc_response,
  input  logic [3:0]  mem2proc_tag,
  input  logic [63:0] mem2proc_data
);

  localparam logic [1:0] CMD_NONE  = 2'd0;
  localparam logic [1:0] CMD_LOAD  = 2'd1;
  localparam logic [1:0] CMD_STORE = 2'd2;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] WB_REQ    = 3'd1;
  localparam logic [2:0] MISS_REQ  = 3'd2;
  localparam logic [2:0] MISS_WAIT = 3'd3;
`ifndef DCACHE_WB_EN
  localparam logic [2:0] WT_STORE  = 3'd4;
`endif

  logic [2:0]  state, state_n;
  logic [12:0] req_line;
  logic        victim;
  logic [3:0]  pend_tag;
  logic        capture, latch_pend;
  logic        is_load, is_store, hit, way_sel;
  logic [8:0]  req_tag;
  logic [3:0]  req_idx;
  logic        unused_bits;

`ifdef DCACHE_WB_EN
  logic [1:0][15:0] dirty;
  logic             set_dirty, clr_dirty, victim_dirty;
  assign victim_dirty = dirty[cache_lru][proc2dcache_addr[6:3]];
`else
  logic [63:0]      req_data;
`endif

  assign is_load     = (proc2dcache_command == CMD_LOAD);
  assign is_store    = (proc2dcache_command == CMD_STORE);
  assign hit         = cache_hit_way0 | cache_hit_way1;
  // A double hit resolves to way 0.
  assign way_sel     = hit ? ~cache_hit_way0 : cache_lru;
  assign req_tag     = req_line[12:4];
  assign req_idx     = req_line[3:0];
  assign unused_bits = ^{proc2dcache_addr[2:0], cache_tag_out};

  always_comb begin
    state_n              = state;
    capture              = 1'b0;
    latch_pend           = 1'b0;
    dcache2proc_data     = '0;
    dcache2proc_valid    = 1'b0;
    dcache2proc_stall    = 1'b0;
    cache_index          = '0;
    cache_tag            = '0;
    cache_wr_data        = '0;
    cache_wr_en          = 1'b0;
    cache_write_back     = 1'b0;
    cache_write_back_way = 1'b0;
    proc2mem_command     = CMD_NONE;
    proc2mem_addr        = '0;
    proc2mem_data        = '0;
`ifdef DCACHE_WB_EN
    set_dirty            = 1'b0;
    clr_dirty            = 1'b0;
`endif
    if (!reset) begin
      if (state != IDLE) begin
        cache_index          = req_idx;
        cache_tag            = req_tag;
        cache_write_back_way = victim;
        dcache2proc_stall    = 1'b1;
      end
      case (state)
        IDLE: begin
          cache_index = proc2dcache_addr[6:3];
          cache_tag   = proc2dcache_addr[15:7];
          if (is_load || is_store) begin
            cache_write_back_way = way_sel;
            if (hit && is_load) begin
              dcache2proc_valid = 1'b1;
              dcache2proc_data  = cache_rd_data;
            end
`ifdef DCACHE_WB_EN
            else if (hit) begin
              cache_wr_en       = 1'b1;
              cache_wr_data     = proc2dcache_data;
              dcache2proc_valid = 1'b1;
              set_dirty         = 1'b1;
            end else begin
              dcache2proc_stall = 1'b1;
              capture           = 1'b1;
              if (victim_dirty)
                state_n = WB_REQ;
              else if (is_load)
                state_n = MISS_REQ;
              else begin
                // Full-word store allocates without a fetch.
                cache_wr_en       = 1'b1;
                cache_wr_data     = proc2dcache_data;
                dcache2proc_valid = 1'b1;
                set_dirty         = 1'b1;
              end
            end
`else
            else begin
              dcache2proc_stall = 1'b1;
              capture           = 1'b1;
              if (is_load)
                state_n = MISS_REQ;
              else begin
                cache_wr_en   = 1'b1;
                cache_wr_data = proc2dcache_data;
                state_n       = WT_STORE;
              end
            end
`endif
          end
        end
`ifdef DCACHE_WB_EN
        WB_REQ: begin
          cache_write_back = 1'b1;
          proc2mem_command = CMD_STORE;
          proc2mem_addr    = {cache_tag_out, req_idx, 3'b000};
          proc2mem_data    = cache_rd_data;
          if (mem2proc_response != 4'd0) begin
            clr_dirty = 1'b1;
            state_n   = IDLE;
          end
        end
`endif
        MISS_REQ: begin
          proc2mem_command = CMD_LOAD;
          proc2mem_addr    = {req_tag, req_idx, 3'b000};
          if (mem2proc_response != 4'd0) begin
            latch_pend = 1'b1;
            state_n    = MISS_WAIT;
          end
        end
        MISS_WAIT: begin
          if (mem2proc_tag != 4'd0 && mem2proc_tag == pend_tag) begin
            cache_wr_en       = 1'b1;
            cache_wr_data     = mem2proc_data;
            dcache2proc_valid = 1'b1;
            dcache2proc_data  = mem2proc_data;
`ifdef DCACHE_WB_EN
            clr_dirty         = 1'b1;
`endif
            state_n           = IDLE;
          end
        end
`ifndef DCACHE_WB_EN
        WT_STORE: begin
          proc2mem_command = CMD_STORE;
          proc2mem_addr    = {req_tag, req_idx, 3'b000};
          proc2mem_data    = req_data;
          if (mem2proc_response != 4'd0) begin
            dcache2proc_valid = 1'b1;
            state_n           = IDLE;
          end
        end
`endif
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      req_line <= '0;
      victim   <= 1'b0;
      pend_tag <= '0;
`ifdef DCACHE_WB_EN
      dirty    <= '0;
`else
      req_data <= '0;
`endif
    end else begin
      state <= state_n;
      if (capture) begin
        req_line <= proc2dcache_addr[15:3];
        victim   <= way_sel;
`ifndef DCACHE_WB_EN
        req_data <= proc2dcache_data;
`endif
      end
      if (latch_pend)
        pend_tag <= mem2proc_response;
`ifdef DCACHE_WB_EN
      if (set_dirty)
        dirty[way_sel][proc2dcache_addr[6:3]] <= 1'b1;
      if (clr_dirty)
        dirty[victim][req_idx] <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl; the cache-array status inputs are driven by hand each step.
module tb_dcache_ctrl;
  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  proc2dcache_command;
  logic [15:0] proc2dcache_addr;
  logic [63:0] proc2dcache_data;
  logic [63:0] dcache2proc_data;
  logic        dcache2proc_valid, dcache2proc_stall;
  logic [3:0]  cache_index;
  logic [8:0]  cache_tag;
  logic [63:0] cache_wr_data;
  logic        cache_wr_en, cache_write_back, cache_write_back_way;
  logic        cache_hit_way0, cache_hit_way1, cache_lru;
  logic [63:0] cache_rd_data;
  logic [8:0]  cache_tag_out;
  logic [1:0]  proc2mem_command;
  logic [15:0] proc2mem_addr;
  logic [63:0] proc2mem_data;
  logic [3:0]  mem2proc_response, mem2proc_tag;
  logic [63:0] mem2proc_data;

  int total = 0;
  int bad   = 0;

  dcache_ctrl dut (
    .clock(clock), .reset(reset),
    .proc2dcache_command(proc2dcache_command), .proc2dcache_addr(proc2dcache_addr),
    .proc2dcache_data(proc2dcache_data), .dcache2proc_data(dcache2proc_data),
    .dcache2proc_valid(dcache2proc_valid), .dcache2proc_stall(dcache2proc_stall),
    .cache_index(cache_index), .cache_tag(cache_tag), .cache_wr_data(cache_wr_data),
    .cache_wr_en(cache_wr_en), .cache_write_back(cache_write_back),
    .cache_write_back_way(cache_write_back_way),
    .cache_hit_way0(cache_hit_way0), .cache_hit_way1(cache_hit_way1), .cache_lru(cache_lru),
    .cache_rd_data(cache_rd_data), .cache_tag_out(cache_tag_out),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
    .proc2mem_data(proc2mem_data), .mem2proc_response(mem2proc_response),
    .mem2proc_tag(mem2proc_tag), .mem2proc_data(mem2proc_data)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic proc(input logic [1:0] cmd, input logic [15:0] addr, input logic [63:0] data);
    proc2dcache_command = cmd;
    proc2dcache_addr    = addr;
    proc2dcache_data    = data;
  endtask

  task automatic arr(input logic h0, input logic h1, input logic lru);
    cache_hit_way0 = h0;
    cache_hit_way1 = h1;
    cache_lru      = lru;
  endtask

  initial begin
    reset = 1'b1;
    proc(2'd1, 16'h1238, 64'h5);
    arr(1'b1, 1'b0, 1'b0);
    cache_rd_data     = 64'hDEAD;
    cache_tag_out     = 9'h0;
    mem2proc_response = 4'd3;
    mem2proc_tag      = 4'd0;
    mem2proc_data     = 64'h0;
    #2;
    check("rst_valid", dcache2proc_valid, 0);
    check("rst_stall", dcache2proc_stall, 0);
    check("rst_wr_en", cache_wr_en, 0);
    check("rst_memcmd", proc2mem_command, 0);
    check("rst_data", dcache2proc_data, 0);
    tick();
    reset = 1'b0;
    proc(2'd0, 16'h0, 64'h0);
    mem2proc_response = 4'd0;
    tick();

    // Cold load miss to 0x1238 (index 7, tag 0x24), victim way 1
    proc(2'd1, 16'h1238, 64'h0);
    arr(1'b0, 1'b0, 1'b1);
    #1;
    check("miss_stall", dcache2proc_stall, 1);
    check("miss_index", cache_index, 7);
    check("miss_tag", cache_tag, 9'h24);
    check("miss_idle_memcmd", proc2mem_command, 0);
    check("miss_idle_valid", dcache2proc_valid, 0);
    tick();
    mem2proc_response = 4'd3;
    #1;
    check("mreq_cmd", proc2mem_command, 1);
    check("mreq_addr", proc2mem_addr, 16'h1238);
    check("mreq_stall", dcache2proc_stall, 1);
    tick();
    mem2proc_response = 4'd0;
    #1;
    check("mwait_cmd", proc2mem_command, 0);
    check("mwait_wr_en", cache_wr_en, 0);
    check("mwait_stall", dcache2proc_stall, 1);
    tick();
    mem2proc_tag  = 4'd3;
    mem2proc_data = 64'hAA;
    #1;
    check("fill_valid", dcache2proc_valid, 1);
    check("fill_data", dcache2proc_data, 64'hAA);
    check("fill_wr_en", cache_wr_en, 1);
    check("fill_wr_data", cache_wr_data, 64'hAA);
    check("fill_index", cache_index, 7);
    check("fill_way", cache_write_back_way, 1);
    tick();
    mem2proc_tag = 4'd0;

    // Repeat load now hits
    arr(1'b1, 1'b0, 1'b0);
    cache_rd_data = 64'hAA;
    #1;
    check("hit_valid", dcache2proc_valid, 1);
    check("hit_data", dcache2proc_data, 64'hAA);
    check("hit_stall", dcache2proc_stall, 0);
    check("hit_memcmd", proc2mem_command, 0);
    tick();

    // Load miss 0x2238 with three rejected requests, then tag 5; tag 2 is ignored
    proc(2'd1, 16'h2238, 64'h0);
    arr(1'b0, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      check("retry_cmd", proc2mem_command, 1);
      tick();
    end
    mem2proc_response = 4'd5;
    #1;
    check("retry_last_cmd", proc2mem_command, 1);
    check("retry_addr", proc2mem_addr, 16'h2238);
    tick();
    mem2proc_response = 4'd0;
    mem2proc_tag      = 4'd2;
    mem2proc_data     = 64'h99;
    #1;
    check("wrongtag_valid", dcache2proc_valid, 0);
    check("wrongtag_wr_en", cache_wr_en, 0);
    tick();
    mem2proc_tag  = 4'd5;
    mem2proc_data = 64'h77;
    #1;
    check("tag5_valid", dcache2proc_valid, 1);
    check("tag5_data", dcache2proc_data, 64'h77);
    check("tag5_way", cache_write_back_way, 0);
    tick();
    mem2proc_tag = 4'd0;
    proc(2'd0, 16'h0, 64'h0);
    tick();

    // Reset while waiting for a fill; the late return must be dropped
    proc(2'd1, 16'h0040, 64'h0);
    arr(1'b0, 1'b0, 1'b0);
    tick();
    mem2proc_response = 4'd1;
    tick();
    mem2proc_response = 4'd0;
    reset = 1'b1;
    #1;
    check("rst_mid_stall", dcache2proc_stall, 0);
    check("rst_mid_memcmd", proc2mem_command, 0);
    tick();
    reset = 1'b0;
    proc(2'd0, 16'h0, 64'h0);
    mem2proc_tag  = 4'd1;
    mem2proc_data = 64'h33;
    #1;
    check("late_wr_en", cache_wr_en, 0);
    check("late_valid", dcache2proc_valid, 0);
    check("late_stall", dcache2proc_stall, 0);
    check("late_memcmd", proc2mem_command, 0);
    tick();
    mem2proc_tag = 4'd0;

`ifdef DCACHE_WB_EN
    // Store hit way 1 marks the line dirty
    proc(2'd2, 16'h1238, 64'h55);
    arr(1'b0, 1'b1, 1'b0);
    #1;
    check("st_hit_wr_en", cache_wr_en, 1);
    check("st_hit_wr_data", cache_wr_data, 64'h55);
    check("st_hit_valid", dcache2proc_valid, 1);
    check("st_hit_stall", dcache2proc_stall, 0);
    check("st_hit_way", cache_write_back_way, 1);
    tick();
    // Conflicting load evicts dirty way 1
    proc(2'd1, 16'h3238, 64'h0);
    arr(1'b0, 1'b0, 1'b1);
    #1;
    check("evict_stall", dcache2proc_stall, 1);
    check("evict_idle_memcmd", proc2mem_command, 0);
    tick();
    cache_tag_out = 9'h24;
    cache_rd_data = 64'h55;
    #1;
    check("wb_write_back", cache_write_back, 1);
    check("wb_way", cache_write_back_way, 1);
    check("wb_cmd", proc2mem_command, 2);
    check("wb_addr", proc2mem_addr, 16'h1238);
    check("wb_data", proc2mem_data, 64'h55);
    tick();
    mem2proc_response = 4'd2;
    #1;
    check("wb_held_cmd", proc2mem_command, 2);
    tick();
    mem2proc_response = 4'd0;
    #1;
    check("wb_reeval_cmd", proc2mem_command, 0);
    check("wb_reeval_stall", dcache2proc_stall, 1);
    check("wb_reeval_wb", cache_write_back, 0);
    tick();
    mem2proc_response = 4'd6;
    #1;
    check("wb_load_cmd", proc2mem_command, 1);
    check("wb_load_addr", proc2mem_addr, 16'h3238);
    tick();
    mem2proc_response = 4'd0;
    mem2proc_tag      = 4'd6;
    mem2proc_data     = 64'h11;
    #1;
    check("wb_fill_valid", dcache2proc_valid, 1);
    check("wb_fill_data", dcache2proc_data, 64'h11);
    tick();
    mem2proc_tag = 4'd0;
    // Clean store miss allocates in place, then a conflicting store sees it dirty
    proc(2'd2, 16'h0400, 64'h22);
    arr(1'b0, 1'b0, 1'b0);
    #1;
    check("alloc_wr_en", cache_wr_en, 1);
    check("alloc_valid", dcache2proc_valid, 1);
    check("alloc_way", cache_write_back_way, 0);
    check("alloc_memcmd", proc2mem_command, 0);
    tick();
    proc(2'd2, 16'h0800, 64'h23);
    #1;
    check("alloc_dirty_wr_en", cache_wr_en, 0);
    check("alloc_dirty_valid", dcache2proc_valid, 0);
    tick();
    cache_tag_out = 9'h08;
    #1;
    check("alloc_wb", cache_write_back, 1);
    check("alloc_wb_addr", proc2mem_addr, 16'h0400);
    mem2proc_response = 4'd1;
    tick();
    mem2proc_response = 4'd0;
    proc(2'd0, 16'h0, 64'h0);
    tick();
`else
    // Write-through store with a double hit resolves to way 0
    proc(2'd2, 16'h0010, 64'h1);
    arr(1'b1, 1'b1, 1'b1);
    #1;
    check("wt_wr_en", cache_wr_en, 1);
    check("wt_wr_data", cache_wr_data, 64'h1);
    check("wt_way", cache_write_back_way, 0);
    check("wt_index", cache_index, 2);
    check("wt_stall", dcache2proc_stall, 1);
    check("wt_idle_valid", dcache2proc_valid, 0);
    tick();
    #1;
    check("wt_cmd", proc2mem_command, 2);
    check("wt_addr", proc2mem_addr, 16'h0010);
    check("wt_data", proc2mem_data, 64'h1);
    check("wt_wait_valid", dcache2proc_valid, 0);
    tick();
    mem2proc_response = 4'd4;
    #1;
    check("wt_acc_valid", dcache2proc_valid, 1);
    check("wt_acc_cmd", proc2mem_command, 2);
    tick();
    mem2proc_response = 4'd0;
    proc(2'd0, 16'h0, 64'h0);
    #1;
    check("wt_done_stall", dcache2proc_stall, 0);
    check("wt_done_cmd", proc2mem_command, 0);
    tick();
    // Store miss writes the LRU victim way
    proc(2'd2, 16'h0100, 64'h9);
    arr(1'b0, 1'b0, 1'b1);
    #1;
    check("wt_miss_wr_en", cache_wr_en, 1);
    check("wt_miss_way", cache_write_back_way, 1);
    tick();
    mem2proc_response = 4'd2;
    #1;
    check("wt_miss_addr", proc2mem_addr, 16'h0100);
    tick();
    mem2proc_response = 4'd0;
    proc(2'd0, 16'h0, 64'h0);
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
